// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package seq_pkg;

  localparam int PC_W_DEF = 8;
  localparam logic [7:0] HALT_OP = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_HALT
  } seq_state_t;

endpackage

// File: rtl/seq_pc.sv
// Program counter: reset value, sequential increment with natural wrap, or branch load.
module seq_pc
  import seq_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            branch_take,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (advance) begin
      pc <= branch_take ? branch_target : pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: fetches a byte, drives the decoder for one
// cycle, latches the control word, strobes execute, then advances or branches.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_FETCH  | mem_req high at pc until mem_ack
// S_DECODE | decoder enabled with ir, ctl captured at cycle end
// S_EXEC   | one-cycle ctl_valid strobe
// S_WAIT   | waiting for exec_done
// S_HALT   | HALT_OP fetched; only rst leaves
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic            dec_en,
  output logic [7:0]      dec_a,
  input  logic [7:0]      dec_y,
  output logic [7:0]      ctl,
  output logic            ctl_valid,
  input  logic            exec_done,
  input  logic            branch_take,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  seq_state_t state, state_nxt;
  logic [7:0] ir;
  logic       complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= 8'h00;
      ctl   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH && mem_ack) ir <= mem_rdata;
      if (state == S_DECODE) ctl <= dec_y;
    end
  end

  always_comb begin
    state_nxt = state;
    complete  = 1'b0;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (mem_ack) state_nxt = (mem_rdata == HALT_OP) ? S_HALT : S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC, S_WAIT: begin
        if (exec_done) begin
          complete  = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, pc and ir.
  always_comb begin
    mem_req   = (state == S_FETCH);
    mem_addr  = pc;
    dec_en    = (state == S_DECODE);
    dec_a     = (state == S_DECODE) ? ir : 8'h00;
    ctl_valid = (state == S_EXEC);
    busy      = (state == S_FETCH) || (state == S_DECODE) ||
                (state == S_EXEC)  || (state == S_WAIT);
    halted    = (state == S_HALT);
  end

  seq_pc #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk           (clk),
    .rst           (rst),
    .advance       (complete),
    .branch_take   (branch_take),
    .branch_target (branch_target),
    .pc            (pc)
  );

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a shift-right-by-2 decoder model.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, mem_ack, exec_done, branch_take;
  logic [7:0] mem_rdata, branch_target, dec_y;
  logic       mem_req, dec_en, ctl_valid, busy, halted;
  logic [7:0] mem_addr, dec_a, ctl, pc;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign dec_y = dec_en ? (dec_a >> 2) : 8'h00;

  instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .dec_en        (dec_en),
    .dec_a         (dec_a),
    .dec_y         (dec_y),
    .ctl           (ctl),
    .ctl_valid     (ctl_valid),
    .exec_done     (exec_done),
    .branch_take   (branch_take),
    .branch_target (branch_target),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_decen"}, {31'd0, dec_en}, 32'd0);
    chk({tag, "_deca"}, {24'd0, dec_a}, 32'd0);
    chk({tag, "_ctl"}, {24'd0, ctl}, 32'd0);
    chk({tag, "_cv"}, {31'd0, ctl_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_halt"}, {31'd0, halted}, 32'd0);
    chk({tag, "_pc"}, {24'd0, pc}, 32'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; mem_ack = 0; exec_done = 0; branch_take = 0;
    mem_rdata = 8'h00; branch_target = 8'h00;
    tick(); tick();
    rst = 0;
    chk_reset("rst0");

    // spurious ack / exec_done in IDLE
    mem_ack = 1; mem_rdata = 8'hFF; exec_done = 1;
    tick();
    chk("idle_spur_busy", {31'd0, busy}, 32'd0);
    chk("idle_spur_halt", {31'd0, halted}, 32'd0);
    chk("idle_spur_pc", {24'd0, pc}, 32'd0);

    // back-to-back minimum-time instructions
    mem_rdata = 8'h12; start = 1;
    tick();
    start = 0;
    chk("f0_req", {31'd0, mem_req}, 32'd1);
    chk("f0_addr", {24'd0, mem_addr}, 32'h00);
    chk("f0_decen", {31'd0, dec_en}, 32'd0);
    tick();
    chk("d0_decen", {31'd0, dec_en}, 32'd1);
    chk("d0_deca", {24'd0, dec_a}, 32'h12);
    chk("d0_cv", {31'd0, ctl_valid}, 32'd0);
    tick();
    chk("e0_cv", {31'd0, ctl_valid}, 32'd1);
    chk("e0_ctl", {24'd0, ctl}, 32'h04);
    chk("e0_deca", {24'd0, dec_a}, 32'h00);
    tick();
    chk("f1_addr", {24'd0, mem_addr}, 32'h01);
    chk("f1_pc", {24'd0, pc}, 32'h01);
    chk("f1_cv", {31'd0, ctl_valid}, 32'd0);
    tick();
    chk("d1_cv", {31'd0, ctl_valid}, 32'd0);
    tick();
    chk("e1_cv", {31'd0, ctl_valid}, 32'd1);
    tick();
    chk("f2_pc", {24'd0, pc}, 32'h02);
    chk("f2_addr", {24'd0, mem_addr}, 32'h02);

    // ack delayed three cycles
    mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dly_req", {31'd0, mem_req}, 32'd1);
      chk("dly_addr", {24'd0, mem_addr}, 32'h02);
      chk("dly_decen", {31'd0, dec_en}, 32'd0);
    end
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("dly_d_decen", {31'd0, dec_en}, 32'd1);
    // exec_done is still high here: DECODE must ignore it
    tick();
    chk("dly_e_cv", {31'd0, ctl_valid}, 32'd1);
    chk("dly_e_pc", {24'd0, pc}, 32'h02);
    chk("dly_e_ctl", {24'd0, ctl}, 32'h04);

    // taken branch to 8'h40
    branch_take = 1; branch_target = 8'h40;
    tick();
    branch_take = 0;
    chk("br_addr", {24'd0, mem_addr}, 32'h40);
    chk("br_req", {31'd0, mem_req}, 32'd1);

    // go into WAIT, then reset
    exec_done = 0; mem_ack = 1;
    tick();
    mem_ack = 0;
    tick();
    chk("w_ecv", {31'd0, ctl_valid}, 32'd1);
    tick();
    chk("w_cv", {31'd0, ctl_valid}, 32'd0);
    chk("w_busy", {31'd0, busy}, 32'd1);
    chk("w_pc", {24'd0, pc}, 32'h40);
    rst = 1;
    tick();
    rst = 0;
    chk_reset("rstw");
    exec_done = 1;
    tick();
    exec_done = 0;
    chk("rstw_idle_busy", {31'd0, busy}, 32'd0);
    chk("rstw_idle_pc", {24'd0, pc}, 32'h00);
    chk("rstw_idle_cv", {31'd0, ctl_valid}, 32'd0);

    // branch to 8'hFF then wrap on the sequential increment
    start = 1; mem_ack = 1; mem_rdata = 8'h12; exec_done = 1;
    branch_take = 1; branch_target = 8'hFF;
    tick();
    start = 0;
    tick(); tick(); tick();
    chk("ff_addr", {24'd0, mem_addr}, 32'hFF);
    branch_take = 0;
    tick(); tick(); tick();
    chk("wrap_addr", {24'd0, mem_addr}, 32'h00);
    chk("wrap_req", {31'd0, mem_req}, 32'd1);

    // halt opcode
    mem_rdata = 8'hFF;
    tick();
    mem_ack = 0;
    chk("h_halt", {31'd0, halted}, 32'd1);
    chk("h_busy", {31'd0, busy}, 32'd0);
    chk("h_decen", {31'd0, dec_en}, 32'd0);
    chk("h_cv", {31'd0, ctl_valid}, 32'd0);
    chk("h_ctl", {24'd0, ctl}, 32'h04);
    start = 1; mem_ack = 1;
    tick(); tick();
    chk("h_start_halt", {31'd0, halted}, 32'd1);
    chk("h_start_req", {31'd0, mem_req}, 32'd0);
    chk("h_start_decen", {31'd0, dec_en}, 32'd0);
    start = 0; mem_ack = 0; exec_done = 0;
    rst = 1;
    tick();
    rst = 0;
    chk_reset("rsth");
    tick();
    chk("rsth_idle_busy", {31'd0, busy}, 32'd0);
    chk("rsth_idle_req", {31'd0, mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
